// File: rtl/shop_seq_if.sv
// shop_seq_if: key pulses, item inputs and pricing results of the shop sequencer
interface shop_seq_if;
    logic        cal_p;
    logic        clr_p;
    logic [3:0]  weight;
    logic [3:0]  per;
    logic [7:0]  price;
    logic [7:0]  times;
    logic [15:0] sum;
    logic        state_cal;
    logic        state_reset;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        full;
    modport master(output cal_p, clr_p, weight, per,
                   input price, times, sum, state_cal, state_reset, busy, done, ovf, full);
    modport slave(input cal_p, clr_p, weight, per,
                  output price, times, sum, state_cal, state_reset, busy, done, ovf, full);
endinterface

// File: rtl/shop_seq.sv
// shop_seq: shift-add item pricing with a saturating running total and item count
module shop_seq #(
    parameter int MAX_TIMES = 99,
    parameter int SUM_MAX   = 9999
) (
    input logic       clk100mhz,
    input logic       reset,
    shop_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, ACC, SHOW} state_t;
    state_t      state;
    logic [1:0]  step;
    logic [3:0]  w;
    logic [3:0]  p;
    logic [7:0]  prod;
    logic [16:0] acc_sum;
    assign acc_sum  = {1'b0, bus.sum} + {9'b0, prod};
    assign bus.full = (bus.times == 8'(MAX_TIMES));
    always_ff @(posedge clk100mhz) begin
        if (!reset) begin
            state           <= IDLE;
            step            <= '0;
            w               <= '0;
            p               <= '0;
            prod            <= '0;
            bus.price       <= '0;
            bus.times       <= '0;
            bus.sum         <= '0;
            bus.ovf         <= 1'b0;
            bus.done        <= 1'b0;
            bus.state_reset <= 1'b0;
            bus.busy        <= 1'b0;
            bus.state_cal   <= 1'b0;
        end else if (bus.clr_p) begin
            // clear wins over any concurrent cal_p and drops an item in flight
            state           <= IDLE;
            step            <= '0;
            prod            <= '0;
            bus.price       <= '0;
            bus.times       <= '0;
            bus.sum         <= '0;
            bus.ovf         <= 1'b0;
            bus.done        <= 1'b0;
            bus.state_reset <= 1'b1;
            bus.busy        <= 1'b0;
            bus.state_cal   <= 1'b0;
        end else begin
            bus.done        <= 1'b0;
            bus.state_reset <= 1'b0;
            case (state)
                IDLE, SHOW: begin
                    if (bus.cal_p && !bus.full) begin
                        w             <= bus.weight;
                        p             <= bus.per;
                        prod          <= '0;
                        step          <= '0;
                        bus.busy      <= 1'b1;
                        bus.state_cal <= 1'b0;
                        state         <= MUL;
                    end
                end
                MUL: begin
                    if (w[step]) prod <= prod + ({4'b0, p} << step);
                    step <= step + 2'd1;
                    if (step == 2'd3) state <= ACC;
                end
                ACC: begin
                    bus.price     <= prod;
                    bus.times     <= bus.times + 8'd1;
                    bus.sum       <= (acc_sum > 17'(SUM_MAX)) ? 16'(SUM_MAX) : acc_sum[15:0];
                    if (acc_sum > 17'(SUM_MAX)) bus.ovf <= 1'b1;
                    bus.done      <= 1'b1;
                    bus.busy      <= 1'b0;
                    bus.state_cal <= 1'b1;
                    state         <= SHOW;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
